// File: rtl/cache_refill_engine.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_engine
// Description : Line-fill engine for a cache miss. Issues one burst read to
//               main memory, streams the returned beats into the cache data
//               memory one word per beat, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = $clog2(DEPTH),
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_ADDR_WIDTH = 32,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int IDX_W         = ADDR_WIDTH - OFF_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // refill request from the cache controller
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [IDX_W-1:0]          req_line_idx,
  input  logic [MEM_ADDR_WIDTH-1:0] req_mem_addr,
  // burst read command to main memory
  output logic                      mem_rd_valid,
  input  logic                      mem_rd_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  // returned beats (no backpressure)
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,
  // data memory write port
  output logic                      dm_wrEn,
  output logic [ADDR_WIDTH-1:0]     dm_waddress,
  output logic [DATA_WIDTH-1:0]     dm_inData,
  // status
  output logic                      busy,
  output logic                      done
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          line_idx_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [OFF_W-1:0]          beat_cnt_q;
  logic                      wr_en_q;
  logic [ADDR_WIDTH-1:0]     waddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  // A beat counts only while filling; responses in any other state are dropped.
  logic beat_take;
  logic req_take;
  assign beat_take = (state_q == S_FILL) && mem_resp_valid;
  assign req_take  = (state_q == S_IDLE) && req_valid;

  // Next-state logic: one command, WORDS_PER_LINE beats, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid)                               state_d = S_CMD;
      S_CMD:  if (mem_rd_ready)                            state_d = S_FILL;
      S_FILL: if (mem_resp_valid && beat_cnt_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:                                              state_d = S_IDLE;
      default:                                             state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any refill in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request capture, beat counting and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_idx_q <= '0;
      mem_addr_q <= '0;
      beat_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      if (req_take) begin
        line_idx_q <= req_line_idx;
        mem_addr_q <= req_mem_addr;
        beat_cnt_q <= '0;
      end else if (beat_take) begin
        // Wraps naturally at WORDS_PER_LINE since the counter is OFF_W wide.
        beat_cnt_q <= beat_cnt_q + OFF_W'(1);
      end
      wr_en_q <= beat_take;
      if (beat_take) begin
        waddr_q <= {line_idx_q, beat_cnt_q};
        wdata_q <= mem_resp_data;
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign mem_rd_valid = (state_q == S_CMD);
  assign mem_rd_addr  = mem_addr_q;
  assign dm_wrEn      = wr_en_q;
  assign dm_waddress  = waddr_q;
  assign dm_inData    = wdata_q;

endmodule
`default_nettype wire
